// File: rtl/mips_lsu_pkg.sv
// Shared types for the simple_mips load/store unit: micro-op kinds,
// FSM state encoding and address-error exception codes.
package mips_lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } lsu_state_t;

  localparam logic EXC_ADEL = 1'b0;
  localparam logic EXC_ADES = 1'b1;

  function automatic logic is_store(input lsu_op_t kind);
    return (kind == OP_SB) || (kind == OP_SH) || (kind == OP_SW);
  endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// Combinational lane logic: misalignment check, store byte enables and
// lane-replicated store data, load lane extract with sign/zero extension.
module mips_lsu_align
  import mips_lsu_pkg::*;
(
  input  lsu_op_t     i_kind,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_misaligned,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_lane [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = i_rdata[8*gi +: 8];
    end
  endgenerate

  assign w_byte = w_lane[i_addr_lo];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_misaligned = 1'b0;
    o_be         = 4'b1111;
    o_wdata      = i_wdata;
    o_ldata      = i_rdata;
    case (i_kind)
      OP_LB:  o_ldata = {{24{w_byte[7]}}, w_byte};
      OP_LBU: o_ldata = {24'd0, w_byte};
      OP_LH: begin
        o_misaligned = i_addr_lo[0];
        o_ldata      = {{16{w_half[15]}}, w_half};
      end
      OP_LHU: begin
        o_misaligned = i_addr_lo[0];
        o_ldata      = {16'd0, w_half};
      end
      OP_LW:  o_misaligned = |i_addr_lo;
      OP_SB: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      OP_SH: begin
        o_misaligned = i_addr_lo[0];
        o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_wdata[15:0]}};
      end
      OP_SW:  o_misaligned = |i_addr_lo;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit: accepts one memory micro-op, issues a valid/ready memory
// request, and returns an extended load result or an address-error exception.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int WADDR_W = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [2:0]         op_kind,
  input  logic [31:0]        op_addr,
  input  logic [31:0]        op_wdata,
  input  logic [4:0]         op_rd,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_req_we,
  output logic [WADDR_W-1:0] mem_req_addr,
  output logic [3:0]         mem_req_be,
  output logic [31:0]        mem_req_wdata,
  input  logic               mem_rsp_valid,
  input  logic [31:0]        mem_rsp_rdata,
  output logic               wb_valid,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic               exc_valid,
  output logic               exc_code,
  output logic [31:0]        exc_badvaddr,
  output logic               busy
);

  lsu_state_t  r_state;
  lsu_op_t     r_kind;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_we;
  logic [4:0]  r_rd;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  lsu_op_t     w_kind;
  logic [1:0]  w_addr_lo;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;
  logic        w_idle;
  logic        w_in_req;
  logic        w_in_err;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_in_req = (r_state == ST_REQ);
  assign w_in_err = (r_state == ST_ERR);

  // In IDLE the lane logic looks at the incoming op; afterwards at the held op.
  assign w_kind    = w_idle ? lsu_op_t'(op_kind) : r_kind;
  assign w_addr_lo = w_idle ? op_addr[1:0] : r_addr[1:0];

  mips_lsu_align u_align (
    .i_kind       (w_kind),
    .i_addr_lo    (w_addr_lo),
    .i_wdata      (op_wdata),
    .i_rdata      (mem_rsp_rdata),
    .o_misaligned (w_misaligned),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_ldata      (w_ldata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_kind    <= OP_LB;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_we      <= 1'b0;
      r_rd      <= '0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (op_valid) begin
            r_kind  <= lsu_op_t'(op_kind);
            r_addr  <= op_addr;
            r_wdata <= w_wdata;
            r_be    <= w_be;
            r_we    <= is_store(lsu_op_t'(op_kind));
            r_rd    <= op_rd;
            r_state <= w_misaligned ? ST_ERR : ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            r_state <= r_we ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            r_wb_data <= w_ldata;
            r_wb_rd   <= r_rd;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign op_ready = w_idle & ~reset;
  assign busy     = ~w_idle;

  // Request fields are only driven while a request is outstanding.
  assign mem_req_valid = w_in_req;
  assign mem_req_we    = w_in_req & r_we;
  assign mem_req_addr  = w_in_req ? r_addr[WADDR_W+1:2] : '0;
  assign mem_req_be    = w_in_req ? r_be : 4'b0000;
  assign mem_req_wdata = w_in_req ? r_wdata : 32'd0;

  assign wb_valid = (r_state == ST_DONE);
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;

  assign exc_valid    = w_in_err;
  assign exc_code     = w_in_err & (r_we ? EXC_ADES : EXC_ADEL);
  assign exc_badvaddr = w_in_err ? r_addr : 32'd0;

endmodule

// File: tb/tb_mips_lsu.sv
// Directed bench for mips_lsu: a bench-side memory, a transaction-level model
// of expected requests/results/timing, and a per-cycle compare process.
module tb_mips_lsu;

  localparam int K_LB = 0, K_LBU = 1, K_LH = 2, K_LHU = 3, K_LW = 4,
                 K_SB = 5, K_SH = 6, K_SW = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op_kind = 3'd0;
  logic [31:0] op_addr = 32'd0;
  logic [31:0] op_wdata = 32'd0;
  logic [4:0]  op_rd = 5'd0;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = 32'd0;

  logic        op_ready, mem_req_valid, mem_req_we, wb_valid, exc_valid, exc_code, busy;
  logic [18:0] mem_req_addr;
  logic [3:0]  mem_req_be;
  logic [31:0] mem_req_wdata, wb_data, exc_badvaddr;
  logic [4:0]  wb_rd;

  mips_lsu #(.WADDR_W(19)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind),
    .op_addr(op_addr), .op_wdata(op_wdata), .op_rd(op_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_badvaddr(exc_badvaddr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- bench memory and responder ----------------
  bit [31:0]   mem [int];
  int          stall_left = 0;
  int          rsp_delay = 0;
  bit          rsp_pending = 0;
  int          rsp_wait = 0;
  logic [31:0] rsp_word = 32'd0;
  bit          stray = 0;
  int          resp_a;
  logic [31:0] resp_mask;

  function automatic logic [31:0] rd_mem(input int a);
    return mem.exists(a) ? mem[a] : 32'd0;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      mem_rsp_valid = stray;
      mem_rsp_rdata = stray ? 32'hCAFEF00D : 32'd0;
      if (rsp_pending) begin
        if (rsp_wait == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = rsp_word;
          rsp_pending   = 0;
        end else begin
          rsp_wait--;
        end
      end
      mem_req_ready = 1'b0;
      if (mem_req_valid && !reset) begin
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          mem_req_ready = 1'b1;
          resp_a = int'(mem_req_addr);
          if (mem_req_we) begin
            resp_mask = {{8{mem_req_be[3]}}, {8{mem_req_be[2]}}, {8{mem_req_be[1]}}, {8{mem_req_be[0]}}};
            mem[resp_a] = (rd_mem(resp_a) & ~resp_mask) | (mem_req_wdata & resp_mask);
          end else begin
            rsp_pending = 1;
            rsp_wait    = rsp_delay;
            rsp_word    = rd_mem(resp_a);
          end
        end
      end
    end
  end

  // ---------------- transaction model ----------------
  task automatic model(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] word, output bit mis, output bit we,
                       output logic [3:0] be, output logic [31:0] wdata,
                       output logic [31:0] ldata);
    int k;
    logic [31:0] b, h;
    k     = int'(addr % 32'd4);
    mis   = 0;
    we    = (kind >= K_SB);
    be    = 4'hF;
    wdata = wd;
    ldata = 32'd0;
    b = (word >> (8 * k)) & 32'hFF;
    h = (word >> (16 * (k / 2))) & 32'hFFFF;
    case (kind)
      K_LB:  ldata = (b >= 32'd128) ? b - 32'd256 : b;
      K_LBU: ldata = b;
      K_LH:  begin mis = (k % 2) != 0; ldata = (h >= 32'd32768) ? h - 32'd65536 : h; end
      K_LHU: begin mis = (k % 2) != 0; ldata = h; end
      K_LW:  begin mis = (k != 0); ldata = word; end
      K_SB:  begin be = 4'(1 << k); wdata = (wd & 32'hFF) * 32'h01010101; end
      K_SH:  begin mis = (k % 2) != 0; be = (k >= 2) ? 4'hC : 4'h3; wdata = (wd & 32'hFFFF) * 32'h00010001; end
      default: mis = (k != 0);
    endcase
  endtask

  bit          exp_active = 0, exp_mis = 0, exp_we = 0, exp_load = 0;
  logic [31:0] exp_req_addr, exp_wdata, exp_ldata, exp_badvaddr;
  logic [3:0]  exp_be;
  logic [4:0]  exp_rd;

  int          req_cycles = 0, wb_seen = 0, exc_seen = 0, wb_cyc = -1, exc_cyc = -1;
  logic [31:0] last_wb_data = 0, last_req_addr = 0, last_req_wdata = 0, last_badvaddr = 0;
  logic [3:0]  last_be = 0;
  logic        last_code = 0;
  logic [4:0]  last_wb_rd = 0;

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("ready_vs_busy", 32'(op_ready), 32'(!busy));
      if (mem_req_valid) begin
        req_cycles++;
        last_req_addr  = 32'(mem_req_addr);
        last_be        = mem_req_be;
        last_req_wdata = mem_req_wdata;
        if (!exp_active || exp_mis) begin
          chk("req_spurious", 32'(mem_req_valid), 32'd0);
        end else begin
          chk("req_we", 32'(mem_req_we), 32'(exp_we));
          chk("req_addr", 32'(mem_req_addr), exp_req_addr);
          chk("req_be", 32'(mem_req_be), 32'(exp_be));
          if (exp_we) chk("req_wdata", mem_req_wdata, exp_wdata);
        end
      end
      if (wb_valid) begin
        wb_seen++;
        wb_cyc       = cyc;
        last_wb_data = wb_data;
        last_wb_rd   = wb_rd;
        if (!exp_active || !exp_load || exp_mis) begin
          chk("wb_spurious", 32'(wb_valid), 32'd0);
        end else begin
          chk("wb_rd", 32'(wb_rd), 32'(exp_rd));
          chk("wb_data", wb_data, exp_ldata);
        end
      end
      if (exc_valid) begin
        exc_seen++;
        exc_cyc       = cyc;
        last_badvaddr = exc_badvaddr;
        last_code     = exc_code;
        if (!exp_active || !exp_mis) begin
          chk("exc_spurious", 32'(exc_valid), 32'd0);
        end else begin
          chk("exc_code", 32'(exc_code), 32'(exp_we));
          chk("exc_badvaddr", exc_badvaddr, exp_badvaddr);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic setup_exp(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] rd);
    logic [31:0] word;
    word = rd_mem(int'((addr >> 2) & 32'h7FFFF));
    model(kind, addr, wd, word, exp_mis, exp_we, exp_be, exp_wdata, exp_ldata);
    exp_load     = (kind < K_SB);
    exp_req_addr = (addr >> 2) & 32'h7FFFF;
    exp_rd       = rd;
    exp_badvaddr = addr;
  endtask

  task automatic present(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, output int t);
    @(negedge clk);
    for (int i = 0; i < 50 && !op_ready; i++) @(negedge clk);
    chk("accept_ready", 32'(op_ready), 32'd1);
    req_cycles = 0; wb_seen = 0; exc_seen = 0; wb_cyc = -1; exc_cyc = -1;
    exp_active = 1;
    op_valid = 1'b1;
    op_kind  = 3'(kind);
    op_addr  = addr;
    op_wdata = wd;
    op_rd    = rd;
    t = cyc;
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input int stall, input int dly);
    int t, lat;
    bit got;
    setup_exp(kind, addr, wd, rd);
    stall_left = stall;
    rsp_delay  = dly;
    present(kind, addr, wd, rd, t);
    got = 0;
    lat = -1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (op_ready) begin got = 1; lat = cyc - t; end
    end
    chk("op_complete", 32'(got), 32'd1);
    if (exp_mis) begin
      chk("exc_latency", 32'(exc_cyc - t), 32'd1);
      chk("ready_latency", 32'(lat), 32'd2);
      chk("req_count", 32'(req_cycles), 32'd0);
      chk("exc_count", 32'(exc_seen), 32'd1);
      chk("wb_count", 32'(wb_seen), 32'd0);
    end else if (exp_we) begin
      chk("ready_latency", 32'(lat), 32'(2 + stall));
      chk("req_count", 32'(req_cycles), 32'(stall + 1));
      chk("wb_count", 32'(wb_seen), 32'd0);
      chk("exc_count", 32'(exc_seen), 32'd0);
    end else begin
      chk("wb_latency", 32'(wb_cyc - t), 32'(3 + stall + dly));
      chk("ready_latency", 32'(lat), 32'(4 + stall + dly));
      chk("req_count", 32'(req_cycles), 32'(stall + 1));
      chk("wb_count", 32'(wb_seen), 32'd1);
      chk("exc_count", 32'(exc_seen), 32'd0);
    end
    exp_active = 0;
    $display("op kind=%0d addr=%h wdata=%h rd=%0d stall=%0d dly=%0d ready_lat=%0d wb=%h exc=%0d",
             kind, addr, wd, rd, stall, dly, lat, last_wb_data, exc_seen);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_op_ready"}, 32'(op_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_req_we"}, 32'(mem_req_we), 32'd0);
    chk({tag, "_req_addr"}, 32'(mem_req_addr), 32'd0);
    chk({tag, "_req_be"}, 32'(mem_req_be), 32'd0);
    chk({tag, "_req_wdata"}, mem_req_wdata, 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_exc_valid"}, 32'(exc_valid), 32'd0);
    chk({tag, "_exc_code"}, 32'(exc_code), 32'd0);
    chk({tag, "_exc_badvaddr"}, exc_badvaddr, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    mem[32'h100] = 32'hDEADBEEF;
    mem[1]       = 32'h00000000;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(op_ready), 32'd1);

    // Loads from word 0x100
    do_op(K_LW, 32'h400, 32'd0, 5'd5, 0, 0);
    chk("lit_lw_addr", last_req_addr, 32'h100);
    chk("lit_lw_be", 32'(last_be), 32'hF);
    chk("lit_lw_rd", 32'(last_wb_rd), 32'd5);
    chk("lit_lw_data", last_wb_data, 32'hDEADBEEF);
    do_op(K_LB, 32'h403, 32'd0, 5'd1, 0, 0);
    chk("lit_lb", last_wb_data, 32'hFFFFFFDE);
    do_op(K_LBU, 32'h401, 32'd0, 5'd2, 0, 0);
    chk("lit_lbu", last_wb_data, 32'h000000BE);
    do_op(K_LH, 32'h402, 32'd0, 5'd3, 0, 0);
    chk("lit_lh", last_wb_data, 32'hFFFFDEAD);
    do_op(K_LHU, 32'h400, 32'd0, 5'd4, 1, 2);
    chk("lit_lhu", last_wb_data, 32'h0000BEEF);

    // Stores, including backpressure
    do_op(K_SB, 32'h5, 32'h000000A5, 5'd0, 3, 0);
    chk("lit_sb_be", 32'(last_be), 32'h2);
    chk("lit_sb_wdata", last_req_wdata, 32'hA5A5A5A5);
    do_op(K_SH, 32'h6, 32'h00001234, 5'd0, 0, 0);
    chk("lit_sh_be", 32'(last_be), 32'hC);
    chk("lit_sh_wdata", last_req_wdata, 32'h12341234);
    do_op(K_SW, 32'h8, 32'h89ABCDEF, 5'd0, 1, 0);
    do_op(K_LW, 32'h4, 32'd0, 5'd0, 0, 0);
    chk("lit_lw_zero_rd", 32'(last_wb_rd), 32'd0);
    chk("lit_lw_merged", last_wb_data, 32'h1234A500);
    do_op(K_LB, 32'h9, 32'd0, 5'd6, 0, 1);
    chk("lit_lb_sw", last_wb_data, 32'hFFFFFFCD);

    // Misaligned accesses
    do_op(K_LW, 32'h402, 32'd0, 5'd7, 0, 0);
    chk("lit_adel_code", 32'(last_code), 32'd0);
    chk("lit_adel_badvaddr", last_badvaddr, 32'h402);
    do_op(K_SH, 32'h1, 32'h5555, 5'd0, 0, 0);
    chk("lit_ades_code", 32'(last_code), 32'd1);
    chk("lit_ades_badvaddr", last_badvaddr, 32'h1);

    // Delayed response, then a stray response while idle
    do_op(K_LW, 32'h400, 32'd0, 5'd8, 1, 5);
    chk("lit_delayed_data", last_wb_data, 32'hDEADBEEF);
    wb_seen = 0;
    @(negedge clk);
    stray = 1;
    @(negedge clk);
    stray = 0;
    repeat (4) @(negedge clk);
    chk("stray_no_wb", 32'(wb_seen), 32'd0);
    $display("stray response in IDLE: wb_seen=%0d", wb_seen);

    // Reset while waiting for a load response
    setup_exp(K_LW, 32'h400, 32'd0, 5'd7);
    stall_left = 0;
    rsp_delay  = 5;
    present(K_LW, 32'h400, 32'd0, 5'd7, t);
    repeat (2) @(negedge clk);
    chk("busy_in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    exp_active = 0;
    @(negedge clk);
    chk_all_zero("midreset");
    reset = 1'b0;
    wb_seen = 0;
    repeat (10) @(negedge clk);
    chk("late_rsp_ignored", 32'(wb_seen), 32'd0);
    $display("reset in WAIT: late response wb_seen=%0d", wb_seen);

    do_op(K_LW, 32'h400, 32'd0, 5'd9, 0, 0);
    chk("lit_after_reset", last_wb_data, 32'hDEADBEEF);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
